uart_rx_deser_v2: RTL and testbench
===================================

Name: uart_rx_deser_v2

Overview:
Parametrised successor to the UART RX deserializer. Collects mid-bit samples into a parallel word with these features:
- runtime frame length (1..MAX_DATA_WIDTH)
- selectable bit order
- output word held stable between frames
- single-cycle completion strobe
- abort on enable drop

Sits between the RX sampler/edge counter and the parity/stop checkers in the UART RX path.

Parameters:
MAX_DATA_WIDTH, 9, widest supported frame; width of P_DATA
PRESCALE_BITS, 6, width of edge_cnt and Prescale
LEN_BITS, 4, width of data_len; must hold MAX_DATA_WIDTH

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
deser_en  input  1  frame window from RX FSM; low aborts/idles
sampled_bit  input  1  majority-voted bit from sampler
edge_cnt  input  PRESCALE_BITS  oversampling edge counter
Prescale  input  PRESCALE_BITS  oversampling ratio
data_len  input  LEN_BITS  data bits per frame, latched at frame start
msb_first  input  1  0 = LSB first, 1 = MSB first, latched at frame start
clear  input  1  synchronous flush of frame state
P_DATA  output  MAX_DATA_WIDTH  last completed word, right-aligned, upper bits zero
data_valid  output  1  one-cycle pulse, P_DATA newly updated
deser_busy  output  1  high in SHIFT state
len_err  output  1  one-cycle pulse, frame start refused due to bad data_len

Behaviour:
- Reset (RST low, async):
  - P_DATA=0, data_valid=0, deser_busy=0, len_err=0.
  - State=IDLE; count, shadow and latched len/order cleared.
- Sample strobe: stb = deser_en && Prescale>=2 && edge_cnt==Prescale-1. Prescale 0 or 1 never strobes.
- Priority each cycle: clear > deser_en low > stb.
- clear: state->IDLE, count/shadow zeroed, data_valid/len_err not asserted. P_DATA keeps its value.
- States: IDLE, SHIFT, DONE.
  - IDLE + stb:
    - data_len==0 or >MAX_DATA_WIDTH: len_err pulses next cycle, stay IDLE, bit discarded.
    - Otherwise: latch len and msb_first, write bit 0, count=1. Go DONE if len==1, else SHIFT.
  - SHIFT + stb: write bit[count], count+1. When the new count equals len, go DONE.
  - SHIFT + deser_en low: abort. Go IDLE, shadow and count zeroed, no data_valid, P_DATA unchanged.
  - DONE: lasts exactly one cycle. In that cycle: P_DATA<=shadow, data_valid=1, then go IDLE. Any stb during DONE is dropped.
- Bit placement:
  - LSB-first: k-th received bit goes to shadow[k].
  - MSB-first: k-th received bit goes to shadow[len-1-k].
  - Bits at index >=len are always 0.
- Latency: data_valid and the new P_DATA appear in the cycle after the clock edge that consumed the last strobe.
- Timing: P_DATA never changes except in DONE or reset, so it is glitch-free for downstream checkers.
- deser_busy=1 exactly while in SHIFT.
- count is LEN_BITS wide and never wraps, since len<=MAX_DATA_WIDTH.

Optional Feature:
UART_RX_DESER_PARITY_EN:
- When defined, adds:
  - input par_type (0 even, 1 odd)
  - output par_bit (1 bit)
- par_bit = XOR of the len received bits, XOR par_type. It is updated together with P_DATA in DONE and resets to 0.
- It is the expected parity bit for the frame.
- When undefined, both ports and all associated logic are absent.

Test Plan:
- Prescale=8, data_len=8, msb_first=0, bits of 0xA5 sent LSB first -> one data_valid pulse, P_DATA=0x0A5.
- Same bits, msb_first=1 -> P_DATA=0x0A5 reversed order, i.e. 0x0A5 when sent as 1,0,1,0,0,1,0,1; check with 0x3C sent MSB first -> P_DATA=0x03C.
- data_len=5, bits 1,1,0,1,0 LSB first -> P_DATA=0x00B, upper bits 0; then data_len=9 with 0x1FF -> P_DATA=0x1FF.
- deser_en dropped after 4 of 8 strobes, previous P_DATA=0x055 -> no data_valid, P_DATA stays 0x055, deser_busy falls next cycle.
- data_len=0 and data_len=10 at first strobe -> len_err pulses once each, state IDLE, P_DATA unchanged. Prescale=1 -> no strobes ever.
- PARITY_EN, par_type=0, frame 0x07 (len 8) -> par_bit=1. Async reset asserted mid-SHIFT -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_deser_v2.sv
// UART RX deserializer: collects mid-bit samples into a right-aligned word of runtime length.
// Optional expected-parity output is enabled by defining UART_RX_DESER_PARITY_EN.
module uart_rx_deser_v2 #(
  parameter int unsigned MAX_DATA_WIDTH = 9,
  parameter int unsigned PRESCALE_BITS  = 6,
  parameter int unsigned LEN_BITS       = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      deser_en,
  input  logic                      sampled_bit,
  input  logic [PRESCALE_BITS-1:0]  edge_cnt,
  input  logic [PRESCALE_BITS-1:0]  Prescale,
  input  logic [LEN_BITS-1:0]       data_len,
  input  logic                      msb_first,
  input  logic                      clear,
`ifdef UART_RX_DESER_PARITY_EN
  input  logic                      par_type,
  output logic                      par_bit,
`endif
  output logic [MAX_DATA_WIDTH-1:0] P_DATA,
  output logic                      data_valid,
  output logic                      deser_busy,
  output logic                      len_err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                    r_state;
  logic [LEN_BITS-1:0]       r_count;
  logic [LEN_BITS-1:0]       r_len;
  logic                      r_msb;
  logic [MAX_DATA_WIDTH-1:0] r_shadow;

  logic                      w_stb;
  logic                      w_len_bad;
  logic                      w_accept;
  logic                      w_last;
  logic [LEN_BITS-1:0]       w_len;
  logic                      w_msb;
  logic [LEN_BITS-1:0]       w_cnt;
  logic [LEN_BITS-1:0]       w_cnt_nxt;
  logic [LEN_BITS-1:0]       w_idx;
  logic [MAX_DATA_WIDTH-1:0] w_shadow_nxt;

  // Prescale below 2 has no usable mid-bit point, so it never strobes.
  assign w_stb     = deser_en && (Prescale >= PRESCALE_BITS'(2)) &&
                     (edge_cnt == Prescale - PRESCALE_BITS'(1));
  assign w_len_bad = (data_len == '0) || (data_len > LEN_BITS'(MAX_DATA_WIDTH));
  assign w_accept  = w_stb && ((r_state == S_SHIFT) || ((r_state == S_IDLE) && !w_len_bad));
  assign w_last    = (w_cnt_nxt == w_len);

  // In IDLE the frame parameters come straight from the inputs (first bit of a frame).
  always_comb begin
    w_len        = r_len;
    w_msb        = r_msb;
    w_cnt        = r_count;
    w_shadow_nxt = r_shadow;
    if (r_state == S_IDLE) begin
      w_len        = data_len;
      w_msb        = msb_first;
      w_cnt        = '0;
      w_shadow_nxt = '0;
    end
    w_cnt_nxt = w_cnt + LEN_BITS'(1);
    w_idx     = w_msb ? (w_len - w_cnt - LEN_BITS'(1)) : w_cnt;
    for (int i = 0; i < int'(MAX_DATA_WIDTH); i++) begin
      if (LEN_BITS'(i) == w_idx) w_shadow_nxt[i] = sampled_bit;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_len      <= '0;
      r_msb      <= 1'b0;
      r_shadow   <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      deser_busy <= 1'b0;
      len_err    <= 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      len_err    <= 1'b0;
      if (clear || !deser_en) begin
        r_state    <= S_IDLE;
        r_count    <= '0;
        r_shadow   <= '0;
        deser_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_SHIFT: begin
            if (w_accept) begin
              if (r_state == S_IDLE) begin
                r_len <= data_len;
                r_msb <= msb_first;
              end
              // Publishing on the consuming edge makes P_DATA/data_valid visible during DONE.
              if (w_last) begin
                r_state    <= S_DONE;
                r_count    <= '0;
                r_shadow   <= '0;
                P_DATA     <= w_shadow_nxt;
                data_valid <= 1'b1;
                deser_busy <= 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
                par_bit    <= (^w_shadow_nxt) ^ par_type;
`endif
              end else begin
                r_state    <= S_SHIFT;
                r_count    <= w_cnt_nxt;
                r_shadow   <= w_shadow_nxt;
                deser_busy <= 1'b1;
              end
            end else if (w_stb && (r_state == S_IDLE)) begin
              len_err <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser_v2.sv
// Randomized self-checking bench for uart_rx_deser_v2 against a word-level reference model.
module tb_uart_rx_deser_v2;

  logic       CLK;
  logic       RST;
  logic       deser_en;
  logic       sampled_bit;
  logic [5:0] edge_cnt;
  logic [5:0] Prescale;
  logic [3:0] data_len;
  logic       msb_first;
  logic       clear;
  logic [8:0] P_DATA;
  logic       data_valid;
  logic       deser_busy;
  logic       len_err;
`ifdef UART_RX_DESER_PARITY_EN
  logic       par_type;
  logic       par_bit;
`endif

  uart_rx_deser_v2 dut (
    .CLK(CLK), .RST(RST), .deser_en(deser_en), .sampled_bit(sampled_bit),
    .edge_cnt(edge_cnt), .Prescale(Prescale), .data_len(data_len),
    .msb_first(msb_first), .clear(clear),
`ifdef UART_RX_DESER_PARITY_EN
    .par_type(par_type), .par_bit(par_bit),
`endif
    .P_DATA(P_DATA), .data_valid(data_valid), .deser_busy(deser_busy), .len_err(len_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  int         vcount;
  int         lcount;
  bit         busy_seen;
  logic [8:0] vq[$];
  logic [8:0] exp_pdata = '0;

  // Word-level model: LSB-first weights bit k by 2^k, MSB-first builds by shift-append.
  function automatic logic [8:0] model(input logic [8:0] seq, input int len, input bit msb);
    int w = 0;
    for (int k = 0; k < len; k++) begin
      if (msb) w = (w << 1) | int'(seq[k]);
      else     w = w + (int'(seq[k]) << k);
    end
    return 9'(w);
  endfunction

  task automatic clr_mon();
    vcount = 0; lcount = 0; busy_seen = 0; vq.delete();
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    if (data_valid) begin vcount++; vq.push_back(P_DATA); end
    if (len_err) lcount++;
    if (deser_busy) busy_seen = 1;
  endtask

  // Non-strobe edges carry the inverted bit so only the mid-bit sample can matter.
  task automatic send_bit(input logic b);
    for (int e = 0; e < int'(Prescale); e++) begin
      edge_cnt    = 6'(e);
      sampled_bit = (e == int'(Prescale) - 1) ? b : ~b;
      tick();
    end
    edge_cnt = '0;
  endtask

  task automatic send_frame(input int len, input logic [8:0] seq, input bit msb, input bit scramble);
    data_len = 4'(len); msb_first = msb; deser_en = 1'b1;
    for (int k = 0; k < len; k++) begin
      send_bit(seq[k]);
      if (scramble && k == 0) begin
        data_len  = 4'($urandom_range(0, 15));
        msb_first = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; deser_en = 0; sampled_bit = 0; edge_cnt = 0; Prescale = 8;
    data_len = 8; msb_first = 0; clear = 0;
`ifdef UART_RX_DESER_PARITY_EN
    par_type = 0;
`endif
    #12;
    checks++; if (P_DATA !== 9'h000) begin errors++; $display("FAIL reset_pdata got=%h exp=000", P_DATA); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    checks++; if (deser_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", deser_busy); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
`ifdef UART_RX_DESER_PARITY_EN
    checks++; if (par_bit !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", par_bit); end
`endif
    @(negedge CLK); RST = 1'b1;
    tick();
  endtask

  task automatic run_frame(input string name, input int len, input logic [8:0] seq, input bit msb);
    logic [8:0] exp;
    exp = model(seq, len, msb);
    clr_mon();
    send_frame(len, seq, msb, 1'b0);
    deser_en = 1'b0; tick(); tick();
    checks++; if (vcount !== 1) begin errors++; $display("FAIL %s_pulses got=%0d exp=1", name, vcount); end
    checks++; if (P_DATA !== exp) begin errors++; $display("FAIL %s_data got=%h exp=%h", name, P_DATA, exp); end
    if (len > 1) begin
      checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", name, busy_seen); end
    end
    exp_pdata = exp;
  endtask

  task automatic test_lsb_first();
    Prescale = 8;
    run_frame("lsb_a5", 8, 9'h0A5, 1'b0);
  endtask

  task automatic test_msb_first();
    logic [8:0] seq = '0;
    logic [7:0] v = 8'h3C;
    for (int k = 0; k < 8; k++) seq[k] = v[7 - k];
    run_frame("msb_3c", 8, seq, 1'b1);
    checks++; if (P_DATA !== 9'h03C) begin errors++; $display("FAIL msb_3c_const got=%h exp=03c", P_DATA); end
  endtask

  task automatic test_lengths();
    run_frame("len5", 5, 9'b0_0000_1011, 1'b0);
    checks++; if (P_DATA !== 9'h00B) begin errors++; $display("FAIL len5_const got=%h exp=00b", P_DATA); end
    run_frame("len9", 9, 9'h1FF, 1'b0);
    checks++; if (P_DATA !== 9'h1FF) begin errors++; $display("FAIL len9_const got=%h exp=1ff", P_DATA); end
    run_frame("len1", 1, 9'h001, 1'b1);
  endtask

  task automatic test_abort();
    run_frame("pre_abort", 8, 9'h055, 1'b0);
    clr_mon();
    data_len = 8; msb_first = 0; deser_en = 1'b1;
    for (int k = 0; k < 4; k++) send_bit(1'($urandom_range(0, 1)));
    checks++; if (deser_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", deser_busy); end
    deser_en = 1'b0; tick();
    checks++; if (deser_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after got=%b exp=0", deser_busy); end
    tick(); tick();
    checks++; if (vcount !== 0) begin errors++; $display("FAIL abort_pulses got=%0d exp=0", vcount); end
    checks++; if (P_DATA !== 9'h055) begin errors++; $display("FAIL abort_data got=%h exp=055", P_DATA); end
  endtask

  task automatic test_len_err();
    logic [3:0] bad[3];
    bad[0] = 4'd0; bad[1] = 4'd10; bad[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      clr_mon();
      data_len = bad[i]; deser_en = 1'b1;
      send_bit(1'b1);
      deser_en = 1'b0; tick(); tick();
      checks++; if (lcount !== 1) begin errors++; $display("FAIL len_err_pulses len=%0d got=%0d exp=1", bad[i], lcount); end
      checks++; if (vcount !== 0 || busy_seen !== 1'b0) begin errors++; $display("FAIL len_err_idle len=%0d valid=%0d busy=%b exp=0/0", bad[i], vcount, busy_seen); end
      checks++; if (P_DATA !== exp_pdata) begin errors++; $display("FAIL len_err_data got=%h exp=%h", P_DATA, exp_pdata); end
    end
  endtask

  task automatic test_small_prescale();
    for (int p = 0; p < 2; p++) begin
      clr_mon();
      Prescale = 6'(p); data_len = 8; deser_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
        edge_cnt = (i % 2 == 0) ? 6'(p - 1) : 6'($urandom_range(0, 63));
        sampled_bit = 1'($urandom_range(0, 1));
        tick();
      end
      deser_en = 1'b0; tick();
      checks++; if (vcount !== 0 || lcount !== 0 || busy_seen !== 1'b0) begin
        errors++; $display("FAIL prescale%0d_strobe valid=%0d lerr=%0d busy=%b exp=0/0/0", p, vcount, lcount, busy_seen);
      end
    end
    Prescale = 8; edge_cnt = 0;
  endtask

  task automatic test_clear();
    logic [8:0] seq;
    clr_mon();
    data_len = 8; msb_first = 0; deser_en = 1'b1;
    for (int k = 0; k < 3; k++) send_bit(1'($urandom_range(0, 1)));
    clear = 1'b1; edge_cnt = 0; tick(); clear = 1'b0;
    checks++; if (deser_busy !== 1'b0 || P_DATA !== exp_pdata) begin
      errors++; $display("FAIL clear_state busy=%b data=%h exp=0/%h", deser_busy, P_DATA, exp_pdata);
    end
    seq = 9'($urandom);
    run_frame("after_clear", 6, seq, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [8:0] sa, sb, ea, eb;
    sa = 9'($urandom); sb = 9'($urandom);
    ea = model(sa, 7, 1'b0); eb = model(sb, 3, 1'b1);
    Prescale = 4;
    clr_mon();
    send_frame(7, sa, 1'b0, 1'b0);
    send_frame(3, sb, 1'b1, 1'b0);
    deser_en = 1'b0; tick(); tick();
    checks++; if (vcount !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", vcount); end
    else begin
      checks++; if (vq[0] !== ea) begin errors++; $display("FAIL b2b_first got=%h exp=%h", vq[0], ea); end
      checks++; if (vq[1] !== eb) begin errors++; $display("FAIL b2b_second got=%h exp=%h", vq[1], eb); end
    end
    exp_pdata = eb;
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int         len;
      bit         msb;
      logic [8:0] seq, exp;
      Prescale = 6'($urandom_range(2, 16));
      len = $urandom_range(1, 9);
      msb = 1'($urandom_range(0, 1));
      seq = 9'($urandom);
      exp = model(seq, len, msb);
      clr_mon();
      send_frame(len, seq, msb, 1'b1);
      deser_en = 1'b0; tick();
      checks++; if (vcount !== 1 || P_DATA !== exp) begin
        errors++; $display("FAIL rand_%0d len=%0d msb=%0d pulses=%0d got=%h exp=%h", it, len, msb, vcount, P_DATA, exp);
      end
      exp_pdata = exp;
    end
    Prescale = 8;
  endtask

`ifdef UART_RX_DESER_PARITY_EN
  task automatic test_parity();
    logic [8:0] seq;
    par_type = 0;
    run_frame("par_07", 8, 9'h007, 1'b0);
    checks++; if (par_bit !== 1'b1) begin errors++; $display("FAIL par_even got=%b exp=1", par_bit); end
    par_type = 1;
    seq = 9'($urandom);
    run_frame("par_rand", 9, seq, 1'b0);
    checks++; if (par_bit !== ((^seq) ^ 1'b1)) begin errors++; $display("FAIL par_odd got=%b exp=%b", par_bit, (^seq) ^ 1'b1); end
    par_type = 0;
  endtask
`endif

  task automatic test_async_reset();
    logic [8:0] seq;
    run_frame("pre_rst", 8, 9'h0C3, 1'b0);
    data_len = 8; msb_first = 0; deser_en = 1'b1;
    for (int k = 0; k < 3; k++) send_bit(1'b1);
    #2; RST = 1'b0; #1;
    checks++; if (P_DATA !== 9'h000 || deser_busy !== 1'b0 || data_valid !== 1'b0 || len_err !== 1'b0) begin
      errors++; $display("FAIL async_rst data=%h busy=%b valid=%b lerr=%b exp=000/0/0/0", P_DATA, deser_busy, data_valid, len_err);
    end
`ifdef UART_RX_DESER_PARITY_EN
    checks++; if (par_bit !== 1'b0) begin errors++; $display("FAIL async_rst_par got=%b exp=0", par_bit); end
`endif
    deser_en = 1'b0;
    @(negedge CLK); RST = 1'b1;
    tick();
    seq = 9'($urandom);
    run_frame("post_rst", 9, seq, 1'b1);
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_lengths();
    test_abort();
    test_len_err();
    test_small_prescale();
    test_clear();
    test_back_to_back();
    test_random();
`ifdef UART_RX_DESER_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
